exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order MIPS pipeline; sits between decode and mem_stage.
- Computes the ALU result and owns the HI/LO registers.
- Runs single-cycle mult/multu and a 32-iteration restoring divider (div/divu) that stalls the stage.
- Issues the data-SRAM request (address, byte enables, aligned store data) for loads and stores.
- Packs the 79-bit bus consumed by the memory stage.

Parameters:
DS_TO_ES_BUS_WD, 166, width of the decode-to-execute bus.
ES_TO_MS_BUS_WD, 79, width of the execute-to-memory bus.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ms_allowin  in  1  memory stage can accept
es_allowin  out  1  execute stage can accept
ds_to_es_valid  in  1  decode output valid
ds_to_es_bus  in  166  {alu_op[12], mdu_op[4]=mult,multu,div,divu, hilo_op[4]=mfhi,mflo,mthi,mtlo, load_op[7]=res_from_mem,lb,lbu,lh,lhu,lwl,lwr, store_op[5]=sb,sh,sw,swl,swr, gr_we, dest[5], src1[32], src2[32], rt_value[32], pc[32]} MSB first
es_to_ms_valid  out  1  instruction handed to memory stage
es_to_ms_bus  out  79  {res_from_mem[78], mem_addr_low[77:76], lb, lbu, lh, lhu, lwl, lwr [75:70], gr_we[69], dest[68:64], result[63:32], pc[31:0]}
data_sram_en  out  1  SRAM access enable
data_sram_wen  out  4  byte write enables
data_sram_addr  out  32  word-aligned address
data_sram_wdata  out  32  lane-aligned store data
es_valid  out  1  stage holds a valid instruction (registered)

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset state: es_valid=0, HI=LO=0, divider FSM=IDLE, count=0. All request outputs are therefore 0 out of reset.
- Handshake: es_allowin = !es_valid || (es_ready_go && ms_allowin); es_to_ms_valid = es_valid && es_ready_go.
- Valid register: when es_allowin, es_valid <= ds_to_es_valid.
- Bus capture: the input bus is latched only when ds_to_es_valid && es_allowin.
- Handoff is the cycle in which es_to_ms_valid && ms_allowin.
- es_ready_go = 1, except for a div/divu with nonzero divisor: it is 1 only in state DONE.
- ALU ops, one-hot: add, sub, slt (signed), sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Shifts use src1[4:0] as the amount and src2 as the value.
  - lui = {src2[15:0],16'b0}.
  - add/sub wrap modulo 2^32; there is no overflow exception.
- result selection: mfhi→HI; mflo→LO; otherwise ALU result (this covers mthi/mtlo and mdu ops, whose gr_we=0).
- mult/multu: 64-bit product of src1 and src2 (signed or unsigned); {HI,LO} written at handoff.
- mthi/mtlo: HI or LO <= src1, written at handoff.
- A following mfhi/mflo sees the new value.
- Divider FSM, states IDLE→BUSY→DONE→IDLE:
  - IDLE→BUSY: es_valid && (div|divu) && src2!=0. Latch |dividend|, |divisor| (magnitudes for div; raw for divu), count=0.
  - BUSY: one restoring step per cycle (shift the remainder/quotient pair left 1, subtract the divisor if it fits, set the quotient bit); count++. BUSY→DONE when the step with count==31 completes.
  - DONE: apply the sign fix for div. Quotient is negated if the operand signs differ; remainder takes the dividend's sign. LO=quotient and HI=remainder at handoff; DONE→IDLE at handoff.
  - Occupancy: a div stays in ES for 34 cycles (1 IDLE + 32 BUSY + 1 DONE) when ms_allowin=1. If ms_allowin=0 in DONE, it holds in DONE.
  - Divide by zero: no FSM entry; ready_go=1 immediately; HI/LO unchanged.
- Reset during BUSY: FSM→IDLE; the instruction is discarded (es_valid=0).
- Memory request:
  - data_sram_en = es_valid && es_ready_go && ms_allowin && (res_from_mem | any store), so read data returns in the cycle the instruction is in MS.
  - data_sram_addr = {alu_result[31:2],2'b00}; mem_addr_low = alu_result[1:0].
  - data_sram_wen = 0 for loads or when data_sram_en=0. For stores, keyed on low:
    - sb: 0001<<low.
    - sh: 0011 if low[1]=0, else 1100.
    - sw: 1111.
    - swl: 00→0001, 01→0011, 10→0111, 11→1111.
    - swr: 00→1111, 01→1110, 10→1100, 11→1000.
  - data_sram_wdata, from rt = rt_value:
    - sb: {4{rt[7:0]}}.
    - sh: {2{rt[15:0]}}.
    - sw: rt.
    - swl: rt >> (8*(3-low)).
    - swr: rt << (8*low).
- Unaligned lh/lhu/sh/sw are not trapped; behaviour follows the low-bit tables above.

Test Plan:
- add src1=0x7FFFFFFF, src2=1, ms_allowin=1 → es_to_ms_valid next cycle after capture, result=0x80000000, 1-cycle throughput for back-to-back ALU ops.
- sb rt=0x000000AB, alu_result=0x1003 → en=1, addr=0x1000, wen=1000, wdata=0xABABABAB. swr with the same address → wen=1000, wdata=0xAB000000.
- mult src1=0xFFFFFFFE(-2), src2=3 then mfhi, mflo → HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div src1=-7, src2=2 → es_allowin=0 for 33 cycles, handoff on cycle 34, LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). divu 100/7 → LO=14, HI=2.
- div with ms_allowin held 0 in DONE for 5 cycles → stays DONE, no HI/LO write, no SRAM request. Releasing ms_allowin → single handoff. divu by 0 → immediate handoff, HI/LO unchanged.
- reset asserted mid-BUSY (count=10) → next cycle es_valid=0, FSM IDLE, HI=LO=0, data_sram_en=0; a new add is accepted on the following cycle.

Source files
------------

// File: rtl/exe_stage_if.sv
// Execute-stage port bundle: decode handshake, memory-stage handshake and data-SRAM request.
interface exe_stage_if #(
  parameter int unsigned DS_TO_ES_BUS_WD = 166,
  parameter int unsigned ES_TO_MS_BUS_WD = 79
);
  logic                       ms_allowin;
  logic                       es_allowin;
  logic                       ds_to_es_valid;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       data_sram_en;
  logic [3:0]                 data_sram_wen;
  logic [31:0]                data_sram_addr;
  logic [31:0]                data_sram_wdata;
  logic                       es_valid;

  // Execute-stage side
  modport master (
    input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
    output es_allowin, es_to_ms_valid, es_to_ms_bus,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, es_valid
  );

  // Surrounding pipeline / memory side
  modport slave (
    output ms_allowin, ds_to_es_valid, ds_to_es_bus,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, es_valid
  );
endinterface

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, HI/LO, single-cycle multiply, 32-step restoring divider, data-SRAM request.
module exe_stage #(
  parameter int unsigned DS_TO_ES_BUS_WD = 166,
  parameter int unsigned ES_TO_MS_BUS_WD = 79
) (
  input logic        clk,
  input logic        reset,
  exe_stage_if.master es_if
);
  typedef struct packed {
    logic [11:0] alu_op;    // add sub slt sltu and nor or xor sll srl sra lui
    logic [3:0]  mdu_op;    // mult multu div divu
    logic [3:0]  hilo_op;   // mfhi mflo mthi mtlo
    logic [6:0]  load_op;   // res_from_mem lb lbu lh lhu lwl lwr
    logic [4:0]  store_op;  // sb sh sw swl swr
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rt_value;
    logic [31:0] pc;
  } ds_bus_t;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_t;

  logic [DS_TO_ES_BUS_WD-1:0] ds_raw;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus;
  ds_bus_t     es_bus;
  logic        es_valid_r;
  logic        es_ready_go, es_allowin, es_to_ms_valid, handoff;
  div_state_t  state, state_nxt;
  logic [4:0]  count;
  logic [31:0] rem, quo, dvsr;
  logic [31:0] hi, lo;
  logic [31:0] src1, src2, rt, alu_result, result;
  logic [4:0]  sa;
  logic [1:0]  low;
  logic        op_mult, op_multu, op_div, op_divu, div_nz;
  logic        dvd_neg, q_neg;
  logic [31:0] dvd_mag, dvs_mag, quo_fix, rem_fix;
  logic [32:0] part, diff;
  logic        fits;
  logic [63:0] prod_s, prod_u;
  logic        mem_req, any_store;
  logic [3:0]  wen_c;
  logic [31:0] wdata_c;

  assign ds_raw   = es_if.ds_to_es_bus;
  assign src1     = es_bus.src1;
  assign src2     = es_bus.src2;
  assign rt       = es_bus.rt_value;
  assign sa       = src1[4:0];
  assign op_mult  = es_bus.mdu_op[3];
  assign op_multu = es_bus.mdu_op[2];
  assign op_div   = es_bus.mdu_op[1];
  assign op_divu  = es_bus.mdu_op[0];
  assign div_nz   = (op_div | op_divu) && (src2 != 32'd0);

  assign es_ready_go    = !div_nz || (state == DONE);
  assign es_allowin     = !es_valid_r || (es_ready_go && es_if.ms_allowin);
  assign es_to_ms_valid = es_valid_r && es_ready_go;
  assign handoff        = es_to_ms_valid && es_if.ms_allowin;

  // Valid flag and bus capture from decode
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_r <= 1'b0;
      es_bus     <= '0;
    end else begin
      if (es_allowin) es_valid_r <= es_if.ds_to_es_valid;
      if (es_if.ds_to_es_valid && es_allowin) es_bus <= ds_bus_t'(ds_raw);
    end
  end

  // One-hot ALU
  always_comb begin
    alu_result = '0;
    if (es_bus.alu_op[11]) alu_result = src1 + src2;
    if (es_bus.alu_op[10]) alu_result = src1 - src2;
    if (es_bus.alu_op[9])  alu_result = {31'b0, $signed(src1) < $signed(src2)};
    if (es_bus.alu_op[8])  alu_result = {31'b0, src1 < src2};
    if (es_bus.alu_op[7])  alu_result = src1 & src2;
    if (es_bus.alu_op[6])  alu_result = ~(src1 | src2);
    if (es_bus.alu_op[5])  alu_result = src1 | src2;
    if (es_bus.alu_op[4])  alu_result = src1 ^ src2;
    if (es_bus.alu_op[3])  alu_result = src2 << sa;
    if (es_bus.alu_op[2])  alu_result = src2 >> sa;
    if (es_bus.alu_op[1])  alu_result = $signed(src2) >>> sa;
    if (es_bus.alu_op[0])  alu_result = {src2[15:0], 16'b0};
  end

  assign result = es_bus.hilo_op[3] ? hi : (es_bus.hilo_op[2] ? lo : alu_result);

  // Multiply and divider operand/step arithmetic
  assign prod_s  = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
  assign prod_u  = {32'b0, src1} * {32'b0, src2};
  assign dvd_neg = op_div & src1[31];
  assign q_neg   = op_div & (src1[31] ^ src2[31]);
  assign dvd_mag = dvd_neg ? -src1 : src1;
  assign dvs_mag = (op_div & src2[31]) ? -src2 : src2;
  assign part    = {rem, quo[31]};
  assign diff    = part - {1'b0, dvsr};
  assign fits    = !diff[32];
  assign quo_fix = q_neg ? -quo : quo;
  assign rem_fix = dvd_neg ? -rem : rem;

  // Divider state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Divider next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (es_valid_r && div_nz) state_nxt = BUSY;
      BUSY:    if (count == 5'd31) state_nxt = DONE;
      DONE:    if (handoff) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Divider datapath: latch magnitudes, then one restoring step per BUSY cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
    end else if (state == IDLE && state_nxt == BUSY) begin
      count <= '0;
      rem   <= '0;
      quo   <= dvd_mag;
      dvsr  <= dvs_mag;
    end else if (state == BUSY) begin
      count <= count + 5'd1;
      rem   <= fits ? diff[31:0] : part[31:0];
      quo   <= {quo[30:0], fits};
    end
  end

  // HI/LO updated only when the instruction leaves the stage
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (handoff) begin
      if (op_mult)  {hi, lo} <= prod_s;
      if (op_multu) {hi, lo} <= prod_u;
      if (div_nz)   {hi, lo} <= {rem_fix, quo_fix};
      if (es_bus.hilo_op[1]) hi <= src1;
      if (es_bus.hilo_op[0]) lo <= src1;
    end
  end

  // Store byte enables and lane-aligned write data
  assign low = alu_result[1:0];
  always_comb begin
    wen_c   = '0;
    wdata_c = '0;
    if (es_bus.store_op[4]) begin
      wen_c   = 4'b0001 << low;
      wdata_c = {4{rt[7:0]}};
    end
    if (es_bus.store_op[3]) begin
      wen_c   = low[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{rt[15:0]}};
    end
    if (es_bus.store_op[2]) begin
      wen_c   = 4'b1111;
      wdata_c = rt;
    end
    if (es_bus.store_op[1]) begin
      case (low)
        2'd0:    begin wen_c = 4'b0001; wdata_c = {24'b0, rt[31:24]}; end
        2'd1:    begin wen_c = 4'b0011; wdata_c = {16'b0, rt[31:16]}; end
        2'd2:    begin wen_c = 4'b0111; wdata_c = {8'b0, rt[31:8]};   end
        default: begin wen_c = 4'b1111; wdata_c = rt;                 end
      endcase
    end
    if (es_bus.store_op[0]) begin
      case (low)
        2'd0:    begin wen_c = 4'b1111; wdata_c = rt;                 end
        2'd1:    begin wen_c = 4'b1110; wdata_c = {rt[23:0], 8'b0};   end
        2'd2:    begin wen_c = 4'b1100; wdata_c = {rt[15:0], 16'b0};  end
        default: begin wen_c = 4'b1000; wdata_c = {rt[7:0], 24'b0};   end
      endcase
    end
  end

  assign any_store = |es_bus.store_op;
  assign mem_req   = handoff && (es_bus.load_op[6] | any_store);
  assign ms_bus    = {es_bus.load_op[6], low, es_bus.load_op[5:0], es_bus.gr_we,
                      es_bus.dest, result, es_bus.pc};

  assign es_if.es_allowin      = es_allowin;
  assign es_if.es_to_ms_valid  = es_to_ms_valid;
  assign es_if.es_to_ms_bus    = ms_bus;
  assign es_if.es_valid        = es_valid_r;
  assign es_if.data_sram_en    = mem_req;
  assign es_if.data_sram_wen   = mem_req ? wen_c : 4'b0000;
  assign es_if.data_sram_addr  = {alu_result[31:2], 2'b00};
  assign es_if.data_sram_wdata = wdata_c;
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed vectors, expected results queued at issue, checked at handoff.
module tb_exe_stage;
  typedef struct {
    logic [31:0] result;
    logic [31:0] pc;
    logic [1:0]  low;
    logic [8:0]  top9;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wd;
  } exp_t;

  localparam logic [11:0] ADD = 12'h800, SUB = 12'h400, SLT = 12'h200, SLTU = 12'h100;
  localparam logic [11:0] AND = 12'h080, NOR = 12'h040, OR = 12'h020, XOR = 12'h010;
  localparam logic [11:0] SLL = 12'h008, SRL = 12'h004, SRA = 12'h002, LUI = 12'h001;
  localparam logic [3:0]  MULT = 4'b1000, MULTU = 4'b0100, DIV = 4'b0010, DIVU = 4'b0001;
  localparam logic [3:0]  MFHI = 4'b1000, MFLO = 4'b0100;
  localparam logic [4:0]  SB = 5'b10000, SH = 5'b01000, SW = 5'b00100, SWL = 5'b00010, SWR = 5'b00001;

  logic clk = 1'b0;
  logic reset;
  exe_stage_if ifc ();
  exe_stage dut (.clk(clk), .reset(reset), .es_if(ifc.master));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] pc_ctr = 32'hBFC0_0000;
  exp_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t ea(input logic [31:0] r);
    exp_t e;
    e.result = r; e.pc = '0; e.low = r[1:0]; e.top9 = '0;
    e.en = 1'b0; e.wen = 4'b0; e.addr = '0; e.wdata = '0; e.chk_wd = 1'b0;
    return e;
  endfunction

  function automatic exp_t eh(input logic [31:0] r);
    exp_t e;
    e = ea(r);
    e.low = 2'b00;
    return e;
  endfunction

  function automatic exp_t em(input logic [31:0] r, input logic [3:0] wen,
                              input logic [31:0] wd, input bit chkwd);
    exp_t e;
    e = ea(r);
    e.en = 1'b1; e.wen = wen; e.addr = {r[31:2], 2'b00}; e.wdata = wd; e.chk_wd = chkwd;
    return e;
  endfunction

  // Drive one instruction and hold it until the stage accepts it
  task automatic send(input logic [11:0] alu, input logic [3:0] mdu, input logic [3:0] hilo,
                      input logic [6:0] ld, input logic [4:0] st, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [31:0] rt, input exp_t e, input bit push);
    exp_t x;
    int n;
    logic acc;
    x = e;
    x.pc = pc_ctr;
    x.top9 = {ld[6], e.low, ld[5:0]};
    if (push) sb_q.push_back(x);
    ifc.ds_to_es_bus = {alu, mdu, hilo, ld, st, 1'b1, 5'd2, s1, s2, rt, pc_ctr};
    ifc.ds_to_es_valid = 1'b1;
    pc_ctr += 32'd4;
    n = 0;
    forever begin
      @(negedge clk);
      acc = ifc.es_allowin;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        checks++; failures++;
        $display("FAIL accept_timeout actual=stalled required=accepted");
        break;
      end
    end
    ifc.ds_to_es_valid = 1'b0;
  endtask

  // Monitor: every handoff pops one expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && ifc.es_to_ms_valid && ifc.ms_allowin) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_handoff actual=handoff required=none pc=%h", ifc.es_to_ms_bus[31:0]);
      end else begin
        e = sb_q.pop_front();
        chk("result", ifc.es_to_ms_bus[63:32], e.result);
        chk("pc", ifc.es_to_ms_bus[31:0], e.pc);
        chk("ld_low_bits", 32'(ifc.es_to_ms_bus[78:70]), 32'(e.top9));
        chk("sram_en", 32'(ifc.data_sram_en), 32'(e.en));
        chk("sram_wen", 32'(ifc.data_sram_wen), 32'(e.wen));
        if (e.en) chk("sram_addr", ifc.data_sram_addr, e.addr);
        if (e.chk_wd) chk("sram_wdata", ifc.data_sram_wdata, e.wdata);
      end
    end
  end

  initial begin
    int t0, n, stall;
    reset = 1'b1;
    ifc.ms_allowin = 1'b1;
    ifc.ds_to_es_valid = 1'b0;
    ifc.ds_to_es_bus = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_es_valid", 32'(ifc.es_valid), 32'd0);
    chk("rst_to_ms_valid", 32'(ifc.es_to_ms_valid), 32'd0);
    chk("rst_sram_en", 32'(ifc.data_sram_en), 32'd0);
    chk("rst_sram_wen", 32'(ifc.data_sram_wen), 32'd0);
    chk("rst_allowin", 32'(ifc.es_allowin), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Back-to-back ALU ops, one per cycle
    t0 = cyc;
    send(ADD,  4'b0, 4'b0, 7'b0, 5'b0, 32'h7FFF_FFFF, 32'h1,         32'h0, ea(32'h8000_0000), 1);
    send(SUB,  4'b0, 4'b0, 7'b0, 5'b0, 32'h5,         32'h7,         32'h0, ea(32'hFFFF_FFFE), 1);
    send(SLT,  4'b0, 4'b0, 7'b0, 5'b0, 32'hFFFF_FFFF, 32'h1,         32'h0, ea(32'h1), 1);
    send(SLTU, 4'b0, 4'b0, 7'b0, 5'b0, 32'hFFFF_FFFF, 32'h1,         32'h0, ea(32'h0), 1);
    send(AND,  4'b0, 4'b0, 7'b0, 5'b0, 32'hF0F0,      32'hFF00,      32'h0, ea(32'hF000), 1);
    send(NOR,  4'b0, 4'b0, 7'b0, 5'b0, 32'h0,         32'h0,         32'h0, ea(32'hFFFF_FFFF), 1);
    send(OR,   4'b0, 4'b0, 7'b0, 5'b0, 32'hF0,        32'h0F,        32'h0, ea(32'hFF), 1);
    send(XOR,  4'b0, 4'b0, 7'b0, 5'b0, 32'hFF,        32'h0F,        32'h0, ea(32'hF0), 1);
    send(SLL,  4'b0, 4'b0, 7'b0, 5'b0, 32'h24,        32'h1,         32'h0, ea(32'h10), 1);
    send(SRL,  4'b0, 4'b0, 7'b0, 5'b0, 32'h4,         32'h8000_0000, 32'h0, ea(32'h0800_0000), 1);
    send(SRA,  4'b0, 4'b0, 7'b0, 5'b0, 32'h4,         32'h8000_0000, 32'h0, ea(32'hF800_0000), 1);
    send(LUI,  4'b0, 4'b0, 7'b0, 5'b0, 32'h0,         32'h1234,      32'h0, ea(32'h1234_0000), 1);
    chk("alu_throughput_cycles", 32'(cyc - t0), 32'd12);

    // Stores and loads
    send(ADD, 4'b0, 4'b0, 7'b0, SB,  32'h1000, 32'h3, 32'h0000_00AB, em(32'h1003, 4'b1000, 32'hABAB_ABAB, 1), 1);
    send(ADD, 4'b0, 4'b0, 7'b0, SWR, 32'h1000, 32'h3, 32'h0000_00AB, em(32'h1003, 4'b1000, 32'hAB00_0000, 1), 1);
    send(ADD, 4'b0, 4'b0, 7'b0, SW,  32'h2000, 32'h0, 32'h1234_5678, em(32'h2000, 4'b1111, 32'h1234_5678, 1), 1);
    send(ADD, 4'b0, 4'b0, 7'b0, SH,  32'h1000, 32'h2, 32'h0000_BEEF, em(32'h1002, 4'b1100, 32'hBEEF_BEEF, 1), 1);
    send(ADD, 4'b0, 4'b0, 7'b0, SWL, 32'h1000, 32'h1, 32'h1122_3344, em(32'h1001, 4'b0011, 32'h0000_1122, 1), 1);
    send(ADD, 4'b0, 4'b0, 7'b1000000, 5'b0, 32'h3000, 32'h0, 32'h0, em(32'h3000, 4'b0000, 32'h0, 0), 1);
    send(ADD, 4'b0, 4'b0, 7'b1010000, 5'b0, 32'h3000, 32'h5, 32'h0, em(32'h3005, 4'b0000, 32'h0, 0), 1);

    // Multiply, then read HI/LO
    send(12'h0, MULT,  4'b0, 7'b0, 5'b0, 32'hFFFF_FFFE, 32'h3, 32'h0, eh(32'h0), 1);
    send(12'h0, 4'b0,  MFHI, 7'b0, 5'b0, 32'h0, 32'h0, 32'h0, eh(32'hFFFF_FFFF), 1);
    send(12'h0, 4'b0,  MFLO, 7'b0, 5'b0, 32'h0, 32'h0, 32'h0, eh(32'hFFFF_FFFA), 1);
    send(12'h0, MULTU, 4'b0, 7'b0, 5'b0, 32'hFFFF_FFFE, 32'h3, 32'h0, eh(32'h0), 1);
    send(12'h0, 4'b0,  MFHI, 7'b0, 5'b0, 32'h0, 32'h0, 32'h0, eh(32'h0000_0002), 1);
    send(12'h0, 4'b0,  MFLO, 7'b0, 5'b0, 32'h0, 32'h0, 32'h0, eh(32'hFFFF_FFFA), 1);

    // Signed divide -7/2: count stall cycles until handoff
    send(12'h0, DIV, 4'b0, 7'b0, 5'b0, 32'hFFFF_FFF9, 32'h2, 32'h0, eh(32'h0), 1);
    stall = 0; n = 0;
    forever begin
      @(negedge clk);
      if (ifc.es_to_ms_valid && ifc.ms_allowin) break;
      if (!ifc.es_allowin) stall++;
      n++;
      if (n > 100) break;
    end
    chk("div_stall_cycles", 32'(stall), 32'd33);
    @(posedge clk); #1;
    send(12'h0, 4'b0, MFLO, 7'b0, 5'b0, 32'h0, 32'h0, 32'h0, eh(32'hFFFF_FFFD), 1);
    send(12'h0, 4'b0, MFHI, 7'b0, 5'b0, 32'h0, 32'h0, 32'h0, eh(32'hFFFF_FFFF), 1);
    send(12'h0, DIVU, 4'b0, 7'b0, 5'b0, 32'd100, 32'd7, 32'h0, eh(32'h0), 1);
    send(12'h0, 4'b0, MFLO, 7'b0, 5'b0, 32'h0, 32'h0, 32'h0, eh(32'd14), 1);
    send(12'h0, 4'b0, MFHI, 7'b0, 5'b0, 32'h0, 32'h0, 32'h0, eh(32'd2), 1);

    // Divide 20/-3 with the memory stage blocked while in DONE
    send(12'h0, DIV, 4'b0, 7'b0, 5'b0, 32'd20, 32'hFFFF_FFFD, 32'h0, eh(32'h0), 1);
    ifc.ms_allowin = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (ifc.es_to_ms_valid) break;
      n++;
      if (n > 100) break;
    end
    chk("div_cycles_to_done", 32'(n), 32'd33);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("done_hold_valid", 32'(ifc.es_to_ms_valid), 32'd1);
      chk("done_hold_sram_en", 32'(ifc.data_sram_en), 32'd0);
      chk("done_hold_allowin", 32'(ifc.es_allowin), 32'd0);
    end
    @(posedge clk); #1;
    ifc.ms_allowin = 1'b1;
    @(posedge clk); #1;
    send(12'h0, 4'b0, MFLO, 7'b0, 5'b0, 32'h0, 32'h0, 32'h0, eh(32'hFFFF_FFFA), 1);
    send(12'h0, 4'b0, MFHI, 7'b0, 5'b0, 32'h0, 32'h0, 32'h0, eh(32'h0000_0002), 1);

    // Divide by zero passes straight through and leaves HI/LO alone
    t0 = cyc;
    send(12'h0, DIVU, 4'b0, 7'b0, 5'b0, 32'd5, 32'd0, 32'h0, eh(32'h0), 1);
    send(12'h0, 4'b0, MFHI, 7'b0, 5'b0, 32'h0, 32'h0, 32'h0, eh(32'h0000_0002), 1);
    send(12'h0, 4'b0, MFLO, 7'b0, 5'b0, 32'h0, 32'h0, 32'h0, eh(32'hFFFF_FFFA), 1);
    chk("div0_no_stall_cycles", 32'(cyc - t0), 32'd3);

    // Reset while the divider is busy at count 10
    send(12'h0, DIV, 4'b0, 7'b0, 5'b0, 32'd9, 32'd2, 32'h0, eh(32'h0), 0);
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("busy_rst_es_valid", 32'(ifc.es_valid), 32'd0);
    chk("busy_rst_to_ms_valid", 32'(ifc.es_to_ms_valid), 32'd0);
    chk("busy_rst_sram_en", 32'(ifc.data_sram_en), 32'd0);
    chk("busy_rst_allowin", 32'(ifc.es_allowin), 32'd1);
    @(posedge clk); #1;
    t0 = cyc;
    send(ADD, 4'b0, 4'b0, 7'b0, 5'b0, 32'd2, 32'd3, 32'h0, ea(32'd5), 1);
    chk("post_rst_accept_cycles", 32'(cyc - t0), 32'd1);
    send(12'h0, 4'b0, MFHI, 7'b0, 5'b0, 32'h0, 32'h0, 32'h0, eh(32'h0), 1);
    send(12'h0, 4'b0, MFLO, 7'b0, 5'b0, 32'h0, 32'h0, 32'h0, eh(32'h0), 1);

    // Drain the scoreboard
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
